// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore decode of state; FETCH PC/IR loads and the MEMWR done pulse are gated by mem_ready.
// Latency: 3-5 cycles per instruction plus one per mem_ready=0 cycle in FETCH/MEMRD/MEMWR; those states hold outputs while waiting.
// Optional macro MC_CTRL_ADDI_EN adds the ADDIEX/ADDIWB path for addi; without it addi decodes as illegal.
module mc_control_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
`ifdef MC_CTRL_ADDI_EN
      , ADDIEX = 4'd10,
      ADDIWB = 4'd11
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t state_q, state_d;
   logic   run_q;

   // Branch resolution happens in the datapath via PCWriteCond & zero.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   assign state = state_q;

   always_comb begin
      state_d     = FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      // The cycle after reset release is idle so the first fetch sees a settled datapath.
      if (run_q) begin
         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               PCWrite = mem_ready;
               IRWrite = mem_ready;
               state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               case (opcode)
                  OP_LW, OP_SW: state_d = MEMADR;
                  OP_RTYPE:     state_d = EXEC;
                  OP_BEQ:       state_d = BRANCH;
                  OP_J:         state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
                  OP_ADDI:      state_d = ADDIEX;
`endif
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = FETCH;
                  end
               endcase
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               MemtoReg   = 1'b1;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            MEMWR: begin
               MemWrite   = 1'b1;
               IorD       = 1'b1;
               instr_done = mem_ready;
               state_d    = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
               state_d = RWB;
            end
            RWB: begin
               RegDst     = 1'b1;
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               instr_done  = 1'b1;
            end
            JUMP: begin
               PCWrite    = 1'b1;
               PCSource   = 2'b10;
               instr_done = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = ADDIWB;
            end
            ADDIWB: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
`endif
            default: state_d = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: path-per-opcode reference model plus directed and randomized scenarios.
module tb_mc_control_fsm;
   logic       clk, rst_n, zero, mem_ready;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic       instr_done, illegal_op;
   logic [3:0] state;

   mc_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
   );

   // bit 15..0: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
   logic [15:0] ctrl;
   assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: each instruction is a list of visited state codes.
   int m_path[$];
   int m_idx;
   bit m_run;
   bit m_illegal;

   logic [3:0]  smp_state;
   logic [15:0] smp_ctrl;
   logic        smp_done, smp_ill;

   task automatic model_reset();
      m_path = '{0};
      m_idx = 0;
      m_run = 1'b0;
      m_illegal = 1'b0;
   endtask

   task automatic build_path(input logic [5:0] op);
      m_illegal = 1'b0;
      case (op)
         6'b100011: m_path = '{0, 1, 2, 3, 4};
         6'b101011: m_path = '{0, 1, 2, 5};
         6'b000000: m_path = '{0, 1, 6, 7};
         6'b000100: m_path = '{0, 1, 8};
         6'b000010: m_path = '{0, 1, 9};
`ifdef MC_CTRL_ADDI_EN
         6'b001000: m_path = '{0, 1, 10, 11};
`endif
         default: begin
            m_path = '{0, 1};
            m_illegal = 1'b1;
         end
      endcase
   endtask

   task automatic model_advance(input logic mr);
      int cur;
      if (!m_run) begin
         m_run = 1'b1;
         return;
      end
      cur = m_path[m_idx];
      if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
      if (m_idx == 0) build_path(opcode);
      m_idx++;
      if (m_idx >= m_path.size()) begin
         m_idx = 0;
         m_path = '{0};
         m_illegal = 1'b0;
      end
   endtask

   function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (s)
         0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin m2r = 1; rw = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rdst = 1; rw = 1; end
         8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
         9:  begin pcw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc};
   endfunction

   // One clock: sample at negedge against the model, then advance the model past the posedge.
   task automatic step();
      logic mr;
      int cur;
      logic [15:0] ec;
      logic [3:0] es;
      logic ed, ei;
      @(negedge clk);
      mr  = mem_ready;
      cur = m_path[m_idx];
      es  = m_run ? 4'(cur) : 4'd0;
      ec  = m_run ? exp_ctrl(cur, mr) : 16'h0;
      ed  = m_run && (cur == 4 || cur == 7 || cur == 8 || cur == 9 || cur == 11 || (cur == 5 && mr));
      ei  = m_run && m_illegal && cur == 1;
      smp_state = state; smp_ctrl = ctrl; smp_done = instr_done; smp_ill = illegal_op;
      n_tests++;
      if (state !== es) begin n_fail++; $display("FAIL state: got %0d expected %0d at %0t", state, es, $time); end
      n_tests++;
      if (ctrl !== ec) begin n_fail++; $display("FAIL ctrl: got %h expected %h (state %0d) at %0t", ctrl, ec, es, $time); end
      n_tests++;
      if (instr_done !== ed) begin n_fail++; $display("FAIL instr_done: got %b expected %b at %0t", instr_done, ed, $time); end
      n_tests++;
      if (illegal_op !== ei) begin n_fail++; $display("FAIL illegal_op: got %b expected %b at %0t", illegal_op, ei, $time); end
      @(posedge clk);
      #1;
      model_advance(mr);
   endtask

   task automatic sync_fetch();
      int n;
      n = 0;
      mem_ready = 1'b1;
      while ((m_idx != 0 || !m_run) && n < 20) begin
         step();
         n++;
      end
      n_tests++;
      if (n >= 20) begin n_fail++; $display("FAIL sync_fetch: no return to FETCH after %0d cycles, need < 20", n); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000010;
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if ({state, ctrl, instr_done, illegal_op} !== 22'h0) begin
            n_fail++; $display("FAIL reset_outputs: got state %0d ctrl %h, need all 0", state, ctrl);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      step();
      n_tests++;
      if (smp_ctrl[12] !== 1'b0) begin n_fail++; $display("FAIL reset_idle_cycle: MemRead %b, need 0", smp_ctrl[12]); end
      step();
      n_tests++;
      if ({smp_ctrl[12], smp_ctrl[10], smp_ctrl[15]} !== 3'b111) begin
         n_fail++; $display("FAIL first_fetch: MemRead/IRWrite/PCWrite %b, need 111", {smp_ctrl[12], smp_ctrl[10], smp_ctrl[15]});
      end
   endtask

   task automatic test_lw();
      int exp_q[$];
      int got_q[$];
      int dcnt;
      bit bad;
      exp_q = '{0, 1, 2, 3, 4};
      sync_fetch();
      opcode = 6'b100011; mem_ready = 1'b1; dcnt = 0; bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         got_q.push_back(int'(smp_state));
         dcnt += int'(smp_done);
         if ((smp_ctrl[7] & smp_ctrl[9]) !== (smp_state == 4'd4)) bad = 1;
      end
      for (int i = 0; i < 5; i++) if (got_q[i] != exp_q[i]) bad = 1;
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL lw_sequence: got %p, need 0,1,2,3,4 with RegWrite&MemtoReg only in 4", got_q); end
      n_tests++;
      if (dcnt != 1) begin n_fail++; $display("FAIL lw_done_count: got %0d need 1", dcnt); end
   endtask

   task automatic test_sw_wait();
      int waits, n5, done5, n;
      bit held_bad, last_done;
      sync_fetch();
      opcode = 6'b101011; waits = 0; n5 = 0; done5 = 0; held_bad = 0; last_done = 0; n = 0;
      do begin
         if (m_path[m_idx] == 5 && waits < 3) begin mem_ready = 1'b0; waits++; end
         else mem_ready = 1'b1;
         step();
         n++;
         if (smp_state == 4'd5) begin
            n5++;
            done5 += int'(smp_done);
            last_done = smp_done;
            if (!(smp_ctrl[11] && smp_ctrl[13])) held_bad = 1;
         end
      end while (m_idx != 0 && n < 20);
      n_tests++;
      if (n5 != 4) begin n_fail++; $display("FAIL sw_wait_cycles: got %0d state-5 cycles need 4", n5); end
      n_tests++;
      if (held_bad) begin n_fail++; $display("FAIL sw_hold: MemWrite/IorD dropped during wait, need held 1"); end
      n_tests++;
      if (done5 != 1 || !last_done) begin n_fail++; $display("FAIL sw_done: got %0d pulses (last %b), need 1 on last cycle", done5, last_done); end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         sync_fetch();
         opcode = 6'b000100; zero = z[0];
         step(); step(); step();
         n_tests++;
         if (smp_state !== 4'd8 || smp_ctrl[14] !== 1'b1 || smp_ctrl[1:0] !== 2'b01 || smp_ctrl[3:2] !== 2'b01) begin
            n_fail++; $display("FAIL beq_zero%0d: state %0d ctrl %h, need state 8 PCWriteCond=1 PCSource=01 ALUOp=01", z, smp_state, smp_ctrl);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_illegal();
      sync_fetch();
      opcode = 6'b111111;
      step(); step();
      n_tests++;
      if (smp_ill !== 1'b1 || smp_ctrl[7] || smp_ctrl[11] || smp_ctrl[15]) begin
         n_fail++; $display("FAIL illegal_decode: illegal_op %b ctrl %h, need 1 with no writes", smp_ill, smp_ctrl);
      end
      step();
      n_tests++;
      if (smp_state !== 4'd0 || smp_ill !== 1'b0) begin
         n_fail++; $display("FAIL illegal_next: state %0d illegal_op %b, need 0 and 0", smp_state, smp_ill);
      end
   endtask

   task automatic test_addi();
      sync_fetch();
      opcode = 6'b001000;
      step(); step();
`ifdef MC_CTRL_ADDI_EN
      step();
      n_tests++;
      if (smp_state !== 4'd10) begin n_fail++; $display("FAIL addi_ex: state %0d need 10", smp_state); end
      step();
      n_tests++;
      if (smp_state !== 4'd11 || smp_ctrl[7] !== 1'b1 || smp_ctrl[8] !== 1'b0) begin
         n_fail++; $display("FAIL addi_wb: state %0d RegWrite %b RegDst %b, need 11 1 0", smp_state, smp_ctrl[7], smp_ctrl[8]);
      end
`else
      n_tests++;
      if (smp_ill !== 1'b1) begin n_fail++; $display("FAIL addi_illegal: illegal_op %b need 1", smp_ill); end
      step();
      n_tests++;
      if (smp_state !== 4'd0) begin n_fail++; $display("FAIL addi_next: state %0d need 0", smp_state); end
`endif
   endtask

   task automatic test_cycle_counts();
      logic [5:0] ops [6];
      int cnts [6];
      int cnt;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
`ifdef MC_CTRL_ADDI_EN
      cnts = '{5, 4, 4, 4, 3, 3};
`else
      cnts = '{5, 4, 4, 2, 3, 3};
`endif
      for (int k = 0; k < 6; k++) begin
         sync_fetch();
         opcode = ops[k];
         step();
         cnt = 1;
         for (int g = 0; g < 12; g++) begin
            step();
            if (smp_state == 4'd0) break;
            cnt++;
         end
         n_tests++;
         if (cnt != cnts[k]) begin n_fail++; $display("FAIL cycles_op%b: got %0d need %0d", ops[k], cnt, cnts[k]); end
      end
   endtask

   task automatic test_async_reset();
      int n;
      sync_fetch();
      opcode = 6'b101011; n = 0;
      while (!(m_path[m_idx] == 5 && mem_ready == 1'b0) && n < 20) begin
         mem_ready = (m_path[m_idx] == 5) ? 1'b0 : 1'b1;
         if (m_path[m_idx] != 5) step();
         n++;
      end
      step();
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (state !== 4'd0 || ctrl !== 16'h0 || instr_done !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: state %0d ctrl %h done %b, need all 0", state, ctrl, instr_done);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      logic [5:0] pick [6];
      pick = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
      for (int c = 0; c < 600; c++) begin
         if (m_idx == 0) begin
            if ($urandom_range(0, 7) == 7) opcode = 6'($urandom);
            else opcode = pick[$urandom_range(0, 5)];
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         zero = 1'($urandom);
         step();
      end
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;
      model_reset();
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq();
      test_illegal();
      test_addi();
      test_cycle_counts();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
